// File: rtl/rr_arbiter4_pkg.sv
// rr_arbiter4_pkg
// Shared definitions for the four-way round-robin arbiter: the requester
// count, the grant index width and the arbiter state enumeration.
package rr_arbiter4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/encoder42.sv
// encoder42
// One-hot (4 bit) to binary (2 bit) encoder. Any input that is not exactly
// one-hot, including all-zero, encodes to 0.
// Ports:
//   onehot : in  [3:0] one-hot vector
//   idx    : out [1:0] binary index of the set bit
module encoder42
  import rr_arbiter4_pkg::*;
(
  input  logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  // Encode the single set bit into its binary position.
  always_comb begin
    idx = 2'd0;
    case (onehot)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4
// Four-requester round-robin arbiter for a shared encoder resource. A grant
// is held until the owner signals done, drops its request, or has held the
// resource for HOLD_MAX cycles; every release is followed by one dead cycle.
// Ports:
//   clk       : in  clock, rising edge
//   rst_n     : in  asynchronous active-low reset
//   req       : in  [3:0] request, bit n = requester n
//   done      : in  current owner releases the resource
//   gnt       : out [3:0] registered one-hot grant
//   gnt_valid : out high when gnt is non-zero
//   gnt_idx   : out [1:0] binary index of the granted requester (0 if none)
//   timeout   : out one-cycle pulse when a grant is revoked by hold expiry
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               timeout
);

  state_t             state_r, state_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_s;
  logic               gnt_valid_r;
  logic [IDX_W-1:0]   ptr_r, ptr_s;
  logic [3:0]         hold_r, hold_s;
  logic               timeout_r, timeout_s;

  logic [IDX_W-1:0]   owner_s;
  logic [NUM_REQ-1:0] win_s;
  logic               found_s;
  logic               hit_s;
  logic [IDX_W-1:0]   cand_s;
  logic [3:0]         hold_inc_s;
  logic               expire_s;
  logic               owner_req_s;
  logic               release_s;

  // Owner index is derived from the registered grant.
  encoder42 u_encoder42 (
    .onehot (gnt_r),
    .idx    (owner_s)
  );

  // Round-robin search: first set request at or above ptr, wrapping 3 -> 0.
  always_comb begin
    win_s   = 4'b0000;
    found_s = 1'b0;
    hit_s   = 1'b0;
    cand_s  = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s  = ptr_r + 2'(i);
      hit_s   = !found_s && req[cand_s];
      win_s   = win_s | ({3'b000, hit_s} << cand_s);
      found_s = found_s | hit_s;
    end
  end

  // Release conditions; hold_inc_s counts the current GRANT cycle too, so
  // expiry fires on the HOLD_MAX-th cycle of ownership. Saturates at 15.
  always_comb begin
    hold_inc_s  = (hold_r == 4'hF) ? hold_r : (hold_r + 4'd1);
    expire_s    = (hold_inc_s == 4'(HOLD_MAX));
    owner_req_s = req[owner_s];
    release_s   = done || !owner_req_s || expire_s;
  end

  // Next-state and next-output logic. GAP is the single mandatory dead
  // cycle; it exits through the same arbitration IDLE performs so exactly
  // one zero-grant cycle separates consecutive grants.
  always_comb begin
    state_s   = state_r;
    gnt_s     = gnt_r;
    ptr_s     = ptr_r;
    hold_s    = hold_r;
    timeout_s = 1'b0;
    case (state_r)
      IDLE, GAP: begin
        if (found_s) begin
          state_s = GRANT;
          gnt_s   = win_s;
          hold_s  = 4'd0;
        end else begin
          state_s = IDLE;
          gnt_s   = 4'b0000;
          hold_s  = 4'd0;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_s   = GAP;
          gnt_s     = 4'b0000;
          ptr_s     = owner_s + 2'd1;
          hold_s    = 4'd0;
          // Expiry only reports when neither done nor a request drop caused it.
          timeout_s = expire_s && !done && owner_req_s;
        end else begin
          hold_s = hold_inc_s;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 4'b0000;
        ptr_s   = 2'd0;
        hold_s  = 4'd0;
      end
    endcase
  end

  // State, grant, pointer, hold counter and timeout registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      gnt_r       <= 4'b0000;
      gnt_valid_r <= 1'b0;
      ptr_r       <= 2'd0;
      hold_r      <= 4'd0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      gnt_r       <= gnt_s;
      gnt_valid_r <= |gnt_s;
      ptr_r       <= ptr_s;
      hold_r      <= hold_s;
      timeout_r   <= timeout_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_valid = gnt_valid_r;
  assign gnt_idx   = owner_s;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4
// Scoreboard bench: each stimulus cycle advances a behavioural model of the
// arbiter (owner / ptr / cycles-held) and queues the expected outputs; a
// monitor pops and compares them after every rising edge.
module tb_rr_arbiter4;

  localparam int HM = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       timeout;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       to;
    int         tag;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   tag_cnt = 0;

  // Reference model state
  int   m_owner = -1;
  int   m_ptr = 0;
  int   m_held = 0;

  rr_arbiter4 #(.HOLD_MAX(HM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input exp_t e);
    vectors++;
    if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.valid || timeout !== e.to) begin
      miscompares++;
      $display("FAIL %s: got gnt=%b idx=%0d valid=%b timeout=%b, want gnt=%b idx=%0d valid=%b timeout=%b",
               name, gnt, gnt_idx, gnt_valid, timeout, e.gnt, e.idx, e.valid, e.to);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
  endtask

  // Apply one cycle of inputs and queue what the outputs must be after the edge.
  task automatic step(input logic [3:0] r, input logic d);
    exp_t e;
    logic tmo;
    tmo = 1'b0;
    @(negedge clk);
    req  = r;
    done = d;
    if (m_owner >= 0) begin
      m_held++;
      if (d || !r[m_owner] || m_held == HM) begin
        tmo     = (m_held == HM) && !d && r[m_owner];
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end
    end else if (r != 4'b0000) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (r[c]) begin
          m_owner = c;
          break;
        end
      end
      m_held = 0;
    end
    e.gnt   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e.idx   = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.valid = (m_owner >= 0);
    e.to    = tmo;
    e.tag   = tag_cnt;
    tag_cnt++;
    sbq.push_back(e);
  endtask

  // Monitor: one expected entry per active edge while out of reset.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && sbq.size() > 0) begin
      e = sbq.pop_front();
      check($sformatf("sb%0d", e.tag), e);
    end
  end

  initial begin
    exp_t zero;
    logic [3:0] r;
    zero.gnt = 4'b0000; zero.idx = 2'd0; zero.valid = 1'b0; zero.to = 1'b0; zero.tag = -1;

    // Reset state
    #12;
    check("reset_state", zero);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, done, then next search starts at 1
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b1);
    step(4'b1111, 1'b0);

    // All requesting, done each grant: rotation with one dead cycle
    for (int k = 0; k < 10; k++) step(4'b1111, (k % 2) == 0);

    // Hold expiry with timeout, repeatedly
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    for (int k = 0; k < 10; k++) step(4'b0100, 1'b0);

    // done coincides with expiry: no timeout
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);

    // Owner 2 drops its request while 0 and 3 request: search from 3
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b0);

    // done in idle/gap is ignored
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      r = 4'($urandom_range(0, 15));
      if (m_owner >= 0 && ($urandom % 4) != 0) r[m_owner] = 1'b1;
      step(r, ($urandom % 5) == 0);
    end

    // Asynchronous reset mid-grant, then search restarts at ptr 0
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0010, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", zero);
    sbq.delete();
    model_reset();
    req  = 4'b0000;
    done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    @(posedge clk);
    #2;
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending entries, want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
